// File: rtl/mem_axi_window_bridge.sv
// AXI4 bridge between the Rocket memory master and the Zynq HP slave port: relocates
// in-window addresses into the PS DRAM window and answers out-of-window accesses with DECERR.
module mem_axi_window_bridge #(
    parameter int          ID_W     = 6,
    parameter int          DATA_W   = 64,
    parameter logic [31:0] IN_BASE  = 32'h8000_0000,
    parameter logic [31:0] OUT_BASE = 32'h1000_0000,
    parameter int          WIN_LOG2 = 28,
    parameter int          MAX_OUT  = 15,
    parameter int          WQ_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    // Rocket side
    input  logic                s_axi_aw_valid,
    output logic                s_axi_aw_ready,
    input  logic [31:0]         s_axi_aw_addr,
    input  logic [ID_W-1:0]     s_axi_aw_id,
    input  logic [7:0]          s_axi_aw_len,
    input  logic [2:0]          s_axi_aw_size,
    input  logic [1:0]          s_axi_aw_burst,
    input  logic                s_axi_aw_lock,
    input  logic [3:0]          s_axi_aw_cache,
    input  logic [2:0]          s_axi_aw_prot,
    input  logic [3:0]          s_axi_aw_qos,
    input  logic                s_axi_w_valid,
    output logic                s_axi_w_ready,
    input  logic [DATA_W-1:0]   s_axi_w_data,
    input  logic [DATA_W/8-1:0] s_axi_w_strb,
    input  logic                s_axi_w_last,
    output logic                s_axi_b_valid,
    input  logic                s_axi_b_ready,
    output logic [ID_W-1:0]     s_axi_b_id,
    output logic [1:0]          s_axi_b_resp,
    input  logic                s_axi_ar_valid,
    output logic                s_axi_ar_ready,
    input  logic [31:0]         s_axi_ar_addr,
    input  logic [ID_W-1:0]     s_axi_ar_id,
    input  logic [7:0]          s_axi_ar_len,
    input  logic [2:0]          s_axi_ar_size,
    input  logic [1:0]          s_axi_ar_burst,
    input  logic                s_axi_ar_lock,
    input  logic [3:0]          s_axi_ar_cache,
    input  logic [2:0]          s_axi_ar_prot,
    input  logic [3:0]          s_axi_ar_qos,
    output logic                s_axi_r_valid,
    input  logic                s_axi_r_ready,
    output logic [ID_W-1:0]     s_axi_r_id,
    output logic [DATA_W-1:0]   s_axi_r_data,
    output logic [1:0]          s_axi_r_resp,
    output logic                s_axi_r_last,
    // PS HP side
    output logic                m_axi_aw_valid,
    input  logic                m_axi_aw_ready,
    output logic [31:0]         m_axi_aw_addr,
    output logic [ID_W-1:0]     m_axi_aw_id,
    output logic [7:0]          m_axi_aw_len,
    output logic [2:0]          m_axi_aw_size,
    output logic [1:0]          m_axi_aw_burst,
    output logic                m_axi_aw_lock,
    output logic [3:0]          m_axi_aw_cache,
    output logic [2:0]          m_axi_aw_prot,
    output logic [3:0]          m_axi_aw_qos,
    output logic                m_axi_w_valid,
    input  logic                m_axi_w_ready,
    output logic [DATA_W-1:0]   m_axi_w_data,
    output logic [DATA_W/8-1:0] m_axi_w_strb,
    output logic                m_axi_w_last,
    input  logic                m_axi_b_valid,
    output logic                m_axi_b_ready,
    input  logic [ID_W-1:0]     m_axi_b_id,
    input  logic [1:0]          m_axi_b_resp,
    output logic                m_axi_ar_valid,
    input  logic                m_axi_ar_ready,
    output logic [31:0]         m_axi_ar_addr,
    output logic [ID_W-1:0]     m_axi_ar_id,
    output logic [7:0]          m_axi_ar_len,
    output logic [2:0]          m_axi_ar_size,
    output logic [1:0]          m_axi_ar_burst,
    output logic                m_axi_ar_lock,
    output logic [3:0]          m_axi_ar_cache,
    output logic [2:0]          m_axi_ar_prot,
    output logic [3:0]          m_axi_ar_qos,
    input  logic                m_axi_r_valid,
    output logic                m_axi_r_ready,
    input  logic [ID_W-1:0]     m_axi_r_id,
    input  logic [DATA_W-1:0]   m_axi_r_data,
    input  logic [1:0]          m_axi_r_resp,
    input  logic                m_axi_r_last,
    output logic [15:0]         err_wr_cnt,
    output logic [15:0]         err_rd_cnt
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_OUT);
    localparam logic [PTR_W:0]   WQ_FULL = (PTR_W+1)'(WQ_DEPTH);

    typedef struct packed {
        logic [31:0]     addr;
        logic [ID_W-1:0] id;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic            lock;
        logic [3:0]      cache;
        logic [2:0]      prot;
        logic [3:0]      qos;
    } ax_t;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_DRAIN, W_RESP} wst_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rst_t;

    function automatic logic in_win(input logic [31:0] a);
        return a[31:WIN_LOG2] == IN_BASE[31:WIN_LOG2];
    endfunction

    // Holds every ready low through reset and the first cycle after it.
    logic run_q;

    ax_t  aw_q, ar_q, aw_in, ar_in;
    logic aw_full_q, ar_full_q;
    logic [CNT_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    wst_t wst_q, wst_d;
    rst_t rst_q, rst_d;
    logic [ID_W-1:0] bid_q, rid_q;
    logic [7:0]      rlen_q, rbeat_q;
    logic [15:0]     err_wr_q, err_rd_q;

    logic [WQ_DEPTH-1:0] wq_mem_q;
    logic [PTR_W-1:0]    wq_wr_q, wq_rd_q;
    logic [PTR_W:0]      wq_cnt_q;
    logic wq_empty, wq_full, wq_push, wq_pop, wq_head_hit;

    logic aw_hit, ar_hit, aw_fire, ar_fire, aw_miss_pop, ar_miss_pop;
    logic b_dec, r_dec, wr_err_done, rd_err_done, r_local_last;

    assign aw_in = '{addr: s_axi_aw_addr, id: s_axi_aw_id, len: s_axi_aw_len,
                     size: s_axi_aw_size, burst: s_axi_aw_burst, lock: s_axi_aw_lock,
                     cache: s_axi_aw_cache, prot: s_axi_aw_prot, qos: s_axi_aw_qos};
    assign ar_in = '{addr: s_axi_ar_addr, id: s_axi_ar_id, len: s_axi_ar_len,
                     size: s_axi_ar_size, burst: s_axi_ar_burst, lock: s_axi_ar_lock,
                     cache: s_axi_ar_cache, prot: s_axi_ar_prot, qos: s_axi_ar_qos};

    assign aw_hit = in_win(aw_q.addr);
    assign ar_hit = in_win(ar_q.addr);

    // AW issue
    assign m_axi_aw_valid = aw_full_q && aw_hit && (wcnt_q < MAX_C) && !wq_full && (wst_q == W_IDLE);
    assign aw_fire        = m_axi_aw_valid && m_axi_aw_ready;
    assign aw_miss_pop    = (wst_q == W_WAIT) && wq_empty && (wcnt_q == '0);
    assign s_axi_aw_ready = run_q && (!aw_full_q || aw_fire);
    assign m_axi_aw_addr  = {OUT_BASE[31:WIN_LOG2], aw_q.addr[WIN_LOG2-1:0]};
    assign m_axi_aw_id    = aw_q.id;
    assign m_axi_aw_len   = aw_q.len;
    assign m_axi_aw_size  = aw_q.size;
    assign m_axi_aw_burst = aw_q.burst;
    assign m_axi_aw_lock  = aw_q.lock;
    assign m_axi_aw_cache = aw_q.cache;
    assign m_axi_aw_prot  = aw_q.prot;
    assign m_axi_aw_qos   = aw_q.qos;

    // AR issue
    assign m_axi_ar_valid = ar_full_q && ar_hit && (rcnt_q < MAX_C) && (rst_q == R_IDLE);
    assign ar_fire        = m_axi_ar_valid && m_axi_ar_ready;
    assign ar_miss_pop    = (rst_q == R_WAIT) && (rcnt_q == '0);
    assign s_axi_ar_ready = run_q && (!ar_full_q || ar_fire);
    assign m_axi_ar_addr  = {OUT_BASE[31:WIN_LOG2], ar_q.addr[WIN_LOG2-1:0]};
    assign m_axi_ar_id    = ar_q.id;
    assign m_axi_ar_len   = ar_q.len;
    assign m_axi_ar_size  = ar_q.size;
    assign m_axi_ar_burst = ar_q.burst;
    assign m_axi_ar_lock  = ar_q.lock;
    assign m_axi_ar_cache = ar_q.cache;
    assign m_axi_ar_prot  = ar_q.prot;
    assign m_axi_ar_qos   = ar_q.qos;

    // W routing: FIFO entry 1 = forward to PS, 0 = sink locally
    assign wq_empty    = (wq_cnt_q == '0);
    assign wq_full     = (wq_cnt_q == WQ_FULL);
    assign wq_head_hit = wq_mem_q[wq_rd_q];
    assign wq_push     = aw_fire || aw_miss_pop;
    assign s_axi_w_ready = !wq_empty && (wq_head_hit ? m_axi_w_ready : 1'b1);
    assign wq_pop        = s_axi_w_valid && s_axi_w_ready && s_axi_w_last;
    assign m_axi_w_valid = !wq_empty && wq_head_hit && s_axi_w_valid;
    assign m_axi_w_data  = s_axi_w_data;
    assign m_axi_w_strb  = s_axi_w_strb;
    assign m_axi_w_last  = s_axi_w_last;

    // B mux: the local response owns the channel only in W_RESP
    assign s_axi_b_valid = (wst_q == W_RESP) ? 1'b1 : (run_q && m_axi_b_valid);
    assign s_axi_b_id    = (wst_q == W_RESP) ? bid_q : m_axi_b_id;
    assign s_axi_b_resp  = (wst_q == W_RESP) ? 2'b11 : m_axi_b_resp;
    assign m_axi_b_ready = run_q && (wst_q != W_RESP) && s_axi_b_ready;
    assign b_dec         = m_axi_b_valid && m_axi_b_ready;
    assign wr_err_done   = (wst_q == W_RESP) && s_axi_b_ready;

    // R mux
    assign r_local_last  = (rbeat_q == rlen_q);
    assign s_axi_r_valid = (rst_q == R_RESP) ? 1'b1 : (run_q && m_axi_r_valid);
    assign s_axi_r_id    = (rst_q == R_RESP) ? rid_q : m_axi_r_id;
    assign s_axi_r_data  = (rst_q == R_RESP) ? '0 : m_axi_r_data;
    assign s_axi_r_resp  = (rst_q == R_RESP) ? 2'b11 : m_axi_r_resp;
    assign s_axi_r_last  = (rst_q == R_RESP) ? r_local_last : m_axi_r_last;
    assign m_axi_r_ready = run_q && (rst_q != R_RESP) && s_axi_r_ready;
    assign r_dec         = m_axi_r_valid && m_axi_r_ready && m_axi_r_last;
    assign rd_err_done   = (rst_q == R_RESP) && s_axi_r_ready && r_local_last;

    assign err_wr_cnt = err_wr_q;
    assign err_rd_cnt = err_rd_q;

    always_comb begin
        wcnt_d = wcnt_q;
        if (aw_fire && !b_dec)
            wcnt_d = wcnt_q + 1'b1;
        else if (!aw_fire && b_dec && wcnt_q != '0)
            wcnt_d = wcnt_q - 1'b1;
        rcnt_d = rcnt_q;
        if (ar_fire && !r_dec)
            rcnt_d = rcnt_q + 1'b1;
        else if (!ar_fire && r_dec && rcnt_q != '0)
            rcnt_d = rcnt_q - 1'b1;
    end

    always_comb begin
        wst_d = wst_q;
        case (wst_q)
            W_IDLE:  if (aw_full_q && !aw_hit) wst_d = W_WAIT;
            W_WAIT:  if (aw_miss_pop)          wst_d = W_DRAIN;
            W_DRAIN: if (wq_pop)               wst_d = W_RESP;
            W_RESP:  if (s_axi_b_ready)        wst_d = W_IDLE;
            default:                           wst_d = W_IDLE;
        endcase
        rst_d = rst_q;
        case (rst_q)
            R_IDLE:  if (ar_full_q && !ar_hit) rst_d = R_WAIT;
            R_WAIT:  if (ar_miss_pop)          rst_d = R_RESP;
            R_RESP:  if (rd_err_done)          rst_d = R_IDLE;
            default:                           rst_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_q     <= 1'b0;
            aw_full_q <= 1'b0;
            ar_full_q <= 1'b0;
            aw_q      <= '0;
            ar_q      <= '0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            wst_q     <= W_IDLE;
            rst_q     <= R_IDLE;
            bid_q     <= '0;
            rid_q     <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            err_wr_q  <= '0;
            err_rd_q  <= '0;
            wq_mem_q  <= '0;
            wq_wr_q   <= '0;
            wq_rd_q   <= '0;
            wq_cnt_q  <= '0;
        end else begin
            run_q  <= 1'b1;
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
            wst_q  <= wst_d;
            rst_q  <= rst_d;

            if (s_axi_aw_valid && s_axi_aw_ready) begin
                aw_q      <= aw_in;
                aw_full_q <= 1'b1;
            end else if (aw_fire || aw_miss_pop) begin
                aw_full_q <= 1'b0;
            end
            if (s_axi_ar_valid && s_axi_ar_ready) begin
                ar_q      <= ar_in;
                ar_full_q <= 1'b1;
            end else if (ar_fire || ar_miss_pop) begin
                ar_full_q <= 1'b0;
            end

            if (wq_push) begin
                wq_mem_q[wq_wr_q] <= aw_fire;
                wq_wr_q           <= wq_wr_q + 1'b1;
            end
            if (wq_pop)
                wq_rd_q <= wq_rd_q + 1'b1;
            if (wq_push && !wq_pop)
                wq_cnt_q <= wq_cnt_q + 1'b1;
            else if (!wq_push && wq_pop)
                wq_cnt_q <= wq_cnt_q - 1'b1;

            if (aw_miss_pop)
                bid_q <= aw_q.id;
            if (wr_err_done && err_wr_q != 16'hFFFF)
                err_wr_q <= err_wr_q + 1'b1;

            if (ar_miss_pop) begin
                rid_q   <= ar_q.id;
                rlen_q  <= ar_q.len;
                rbeat_q <= '0;
            end else if (rst_q == R_RESP && s_axi_r_ready) begin
                rbeat_q <= rbeat_q + 1'b1;
            end
            if (rd_err_done && err_rd_q != 16'hFFFF)
                err_rd_q <= err_rd_q + 1'b1;
        end
    end

    // A response with no matching outstanding request means the PS or the counters are broken.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (!(b_dec && wcnt_q == '0));
            assert (!(r_dec && rcnt_q == '0));
        end
    end

endmodule
